// File: rtl/msrv32_store_bus_unit.sv
// Store bus unit: aligns rs2, builds byte masks, issues one write with req/ack.
// Optional MSRV32_STORE_TIMEOUT_EN aborts a write left unacked for TIMEOUT_CYCLES.
module msrv32_store_bus_unit #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             store_req_in,
  input  logic             flush_in,
  input  logic [1:0]       funct3_in,
  input  logic [WIDTH-1:0] iadder_in,
  input  logic [WIDTH-1:0] rs2_in,
  input  logic             wr_ack_in,
  output logic [WIDTH-1:0] d_addr_out,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       wr_mask_out,
  output logic             wr_req_out,
  output logic             stall_out,
  output logic             misaligned_out,
  output logic             bus_err_out
);

  if (WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("msrv32_store_bus_unit: WIDTH must be 32, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:2] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       mask_q, mask_d;
  logic             mis_q, mis_d;

  logic             is_sb, is_sh, is_sw;
  logic             misal, capture, accept, done, abort;
  logic [WIDTH-1:0] data_new;
  logic [3:0]       mask_new;

  assign is_sb = (funct3_in == 2'b00);
  assign is_sh = (funct3_in == 2'b01);
  assign is_sw = funct3_in[1];

  assign misal = (is_sh & iadder_in[0])
               | (is_sw & (|iadder_in[1:0]));

  assign capture = (state_q == IDLE) & store_req_in & ~flush_in;
  assign accept  = capture & ~misal;
  assign done    = (state_q == REQ) & wr_ack_in;

  always_comb begin
    data_new = rs2_in;
    mask_new = 4'b1111;
    unique case (1'b1)
      is_sb: begin
        data_new = {4{rs2_in[7:0]}};
        mask_new = 4'b0001 << iadder_in[1:0];
      end
      is_sh: begin
        data_new = {2{rs2_in[15:0]}};
        mask_new = iadder_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data_new = rs2_in;
        mask_new = 4'b1111;
      end
    endcase
  end

`ifdef MSRV32_STORE_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter stays zero in IDLE, so it is clear on every entry to REQ.
  assign abort = (state_q == REQ) & ~wr_ack_in
               & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    err_d = abort;
    if (state_q == REQ && !wr_ack_in && !abort) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_err_out = err_q;
`else
  assign abort       = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ:  if (done || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    mis_d  = capture & misal;
    if (accept) begin
      addr_d = iadder_in[WIDTH-1:2];
      data_d = data_new;
      mask_d = mask_new;
    end
  end

  always_comb begin
    d_addr_out     = {addr_q, 2'b00};
    data_out       = data_q;
    wr_mask_out    = mask_q;
    wr_req_out     = (state_q == REQ);
    misaligned_out = mis_q;
    stall_out      = ((state_q == REQ) & ~wr_ack_in) | accept;
  end

endmodule

// File: tb/tb_msrv32_store_bus_unit.sv
// Bench for msrv32_store_bus_unit: vector table, scoreboard, corner sequences.
// Define MSRV32_STORE_TIMEOUT_EN on both files to also exercise the timeout.
module tb_msrv32_store_bus_unit;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        store_req_in;
  logic        flush_in;
  logic [1:0]  funct3_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic        wr_ack_in;
  logic [31:0] d_addr_out;
  logic [31:0] data_out;
  logic [3:0]  wr_mask_out;
  logic        wr_req_out;
  logic        stall_out;
  logic        misaligned_out;
  logic        bus_err_out;

  msrv32_store_bus_unit #(
    .WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .store_req_in(store_req_in),
    .flush_in(flush_in),
    .funct3_in(funct3_in),
    .iadder_in(iadder_in),
    .rs2_in(rs2_in),
    .wr_ack_in(wr_ack_in),
    .d_addr_out(d_addr_out),
    .data_out(data_out),
    .wr_mask_out(wr_mask_out),
    .wr_req_out(wr_req_out),
    .stall_out(stall_out),
    .misaligned_out(misaligned_out),
    .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    int          delay;
    logic        mis;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_mask;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  txn_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_mask = '0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard: completed handshakes are compared against queued stores.
  always @(negedge clk_in) begin
    if (rst_n_in && wr_req_out && wr_ack_in) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = sb_q.pop_front();
        chk("sb_addr", d_addr_out, t.addr);
        chk("sb_data", data_out, t.data);
        chk("sb_mask", {28'd0, wr_mask_out}, {28'd0, t.mask});
      end
    end
  end

  task automatic do_store(input vec_t v, input bit flush_mid);
    store_req_in = 1'b1;
    flush_in     = 1'b0;
    funct3_in    = v.f3;
    iadder_in    = v.addr;
    rs2_in       = v.rs2;
    wr_ack_in    = 1'b0;
    #2;
    chk("stall_on_capture", {31'd0, stall_out}, {31'd0, ~v.mis});
    step();
    store_req_in = flush_mid;
    flush_in     = flush_mid;
    if (v.mis) begin
      #2;
      chk("mis_pulse", {31'd0, misaligned_out}, 32'd1);
      chk("mis_no_req", {31'd0, wr_req_out}, 32'd0);
      chk("mis_no_stall", {31'd0, stall_out}, 32'd0);
      chk("mis_addr_hold", d_addr_out, last_addr);
      step();
      #2;
      chk("mis_pulse_end", {31'd0, misaligned_out}, 32'd0);
      step();
    end else begin
      txn_t t;
      t.addr = v.e_addr;
      t.data = v.e_data;
      t.mask = v.e_mask;
      sb_q.push_back(t);
      for (int i = 0; i < v.delay; i++) begin
        #2;
        chk("req_wait", {31'd0, wr_req_out}, 32'd1);
        chk("stall_wait", {31'd0, stall_out}, 32'd1);
        chk("addr_stable", d_addr_out, v.e_addr);
        chk("data_stable", data_out, v.e_data);
        step();
      end
      store_req_in = 1'b0;
      wr_ack_in    = 1'b1;
      #2;
      chk("req_at_ack", {31'd0, wr_req_out}, 32'd1);
      chk("stall_at_ack", {31'd0, stall_out}, 32'd0);
      step();
      wr_ack_in = 1'b0;
      flush_in  = 1'b0;
      #2;
      chk("req_drop", {31'd0, wr_req_out}, 32'd0);
      chk("addr_hold", d_addr_out, v.e_addr);
      chk("data_hold", data_out, v.e_data);
      last_addr = v.e_addr;
      last_data = v.e_data;
      last_mask = v.e_mask;
      step();
    end
  endtask

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0,
              32'h0000_1000, 32'hDEAD_BEEF, 4'b1111};
    vt[1] = '{2'b00, 32'h0000_2003, 32'h0000_00A5, 3, 1'b0,
              32'h0000_2000, 32'hA5A5_A5A5, 4'b1000};
    vt[2] = '{2'b01, 32'h0000_3002, 32'h1234_5678, 1, 1'b0,
              32'h0000_3000, 32'h5678_5678, 4'b1100};
    vt[3] = '{2'b01, 32'h0000_3001, 32'h1234_5678, 0, 1'b1,
              32'h0, 32'h0, 4'b0000};
    vt[4] = '{2'b00, 32'h0000_4001, 32'hFFFF_FF3C, 0, 1'b0,
              32'h0000_4000, 32'h3C3C_3C3C, 4'b0010};
    vt[5] = '{2'b01, 32'h0000_5000, 32'hAABB_CCDD, 2, 1'b0,
              32'h0000_5000, 32'hCCDD_CCDD, 4'b0011};
    vt[6] = '{2'b11, 32'h0000_6004, 32'h0102_0304, 2, 1'b0,
              32'h0000_6004, 32'h0102_0304, 4'b1111};
    vt[7] = '{2'b10, 32'h0000_6002, 32'h0102_0304, 0, 1'b1,
              32'h0, 32'h0, 4'b0000};
    vt[8] = '{2'b11, 32'h0000_7001, 32'h0102_0304, 0, 1'b1,
              32'h0, 32'h0, 4'b0000};
    vt[9] = '{2'b00, 32'h0000_8002, 32'h0000_0077, 1, 1'b0,
              32'h0000_8000, 32'h7777_7777, 4'b0100};

    rst_n_in     = 1'b0;
    store_req_in = 1'b0;
    flush_in     = 1'b0;
    funct3_in    = 2'b00;
    iadder_in    = '0;
    rs2_in       = '0;
    wr_ack_in    = 1'b0;
    #12;
    chk("rst_addr", d_addr_out, 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_mask", {28'd0, wr_mask_out}, 32'h0);
    chk("rst_req", {31'd0, wr_req_out}, 32'h0);
    chk("rst_mis", {31'd0, misaligned_out}, 32'h0);
    chk("rst_err", {31'd0, bus_err_out}, 32'h0);
    step();
    rst_n_in = 1'b1;
    step();

    // ack while idle must not start anything
    wr_ack_in = 1'b1;
    step();
    #2;
    chk("idle_ack_req", {31'd0, wr_req_out}, 32'd0);
    wr_ack_in = 1'b0;
    step();

    for (int i = 0; i < 10; i++) do_store(vt[i], 1'b0);

    // flush in IDLE suppresses capture
    store_req_in = 1'b1;
    flush_in     = 1'b1;
    funct3_in    = 2'b10;
    iadder_in    = 32'h0000_9000;
    rs2_in       = 32'hCAFE_F00D;
    #2;
    chk("flush_idle_stall", {31'd0, stall_out}, 32'd0);
    step();
    store_req_in = 1'b0;
    flush_in     = 1'b0;
    #2;
    chk("flush_idle_req", {31'd0, wr_req_out}, 32'd0);
    chk("flush_idle_addr", d_addr_out, last_addr);
    step();

    // flush (and a new store request) during REQ do not cancel the write
    do_store('{2'b10, 32'h0000_A000, 32'h1111_2222, 2, 1'b0,
               32'h0000_A000, 32'h1111_2222, 4'b1111}, 1'b1);
    chk("flush_req_data", data_out, 32'h1111_2222);

    // reset mid-transaction aborts it at once
    store_req_in = 1'b1;
    funct3_in    = 2'b10;
    iadder_in    = 32'h0000_B000;
    rs2_in       = 32'h5555_AAAA;
    step();
    store_req_in = 1'b0;
    #2;
    chk("pre_rst_req", {31'd0, wr_req_out}, 32'd1);
    step();
    rst_n_in = 1'b0;
    #1;
    chk("midrst_req", {31'd0, wr_req_out}, 32'd0);
    chk("midrst_addr", d_addr_out, 32'h0);
    chk("midrst_data", data_out, 32'h0);
    chk("midrst_mask", {28'd0, wr_mask_out}, 32'h0);
    chk("midrst_stall", {31'd0, stall_out}, 32'd0);
    step();
    rst_n_in = 1'b1;
    step();
    #2;
    chk("post_rst_no_retry", {31'd0, wr_req_out}, 32'd0);
    step();
    last_addr = '0;
    do_store('{2'b10, 32'h0000_C000, 32'h0BAD_CAFE, 0, 1'b0,
               32'h0000_C000, 32'h0BAD_CAFE, 4'b1111}, 1'b0);

`ifdef MSRV32_STORE_TIMEOUT_EN
    store_req_in = 1'b1;
    funct3_in    = 2'b10;
    iadder_in    = 32'h0000_D000;
    rs2_in       = 32'h1357_9BDF;
    step();
    store_req_in = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #2;
      chk("to_req_held", {31'd0, wr_req_out}, 32'd1);
      chk("to_no_err", {31'd0, bus_err_out}, 32'd0);
      step();
    end
    #2;
    chk("to_req_drop", {31'd0, wr_req_out}, 32'd0);
    chk("to_err_pulse", {31'd0, bus_err_out}, 32'd1);
    chk("to_stall_drop", {31'd0, stall_out}, 32'd0);
    step();
    #2;
    chk("to_err_end", {31'd0, bus_err_out}, 32'd0);
    step();
    do_store('{2'b01, 32'h0000_E002, 32'h0000_BEEF, 1, 1'b0,
               32'h0000_E000, 32'hBEEF_BEEF, 4'b1100}, 1'b0);
`else
    chk("err_tied_low", {31'd0, bus_err_out}, 32'd0);
`endif

    step();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msrv32_store_bus_unit.md
Name: msrv32_store_bus_unit

Overview:
Store-side counterpart to the load/writeback path. It takes a store request from the execute stage, aligns rs2 data and generates byte-lane masks. It then drives a single-outstanding write transaction to the data memory bus with a req/ack handshake, stalling the pipeline until the bus accepts the write. Misaligned stores are detected and reported without issuing a bus request.

Parameters:
WIDTH, 32, data/address width (fixed RV32; lane logic assumes 32)
TIMEOUT_CYCLES, 16, max cycles waiting for ack (used only with the optional feature)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
store_req_in  input  1  execute stage presents a store this cycle
flush_in  input  1  pipeline flush; suppresses capture of a new store
funct3_in  input  2  store size: 00 SB, 01 SH, 10 SW, 11 treated as SW
iadder_in  input  WIDTH  effective byte address (rs1+imm)
rs2_in  input  WIDTH  store source data
wr_ack_in  input  1  bus accepts current write (ready)
d_addr_out  output  WIDTH  word-aligned bus address {addr[31:2],2'b00}
data_out  output  WIDTH  lane-replicated write data
wr_mask_out  output  4  byte-lane enables
wr_req_out  output  1  write request valid
stall_out  output  1  hold the pipeline
misaligned_out  output  1  one-cycle misaligned-store pulse
bus_err_out  output  1  one-cycle timeout pulse (0 when feature compiled out)

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; d_addr_out, data_out, wr_mask_out = 0; wr_req_out, misaligned_out, bus_err_out = 0. Reset asserted mid-transaction aborts it immediately. No retry after reset.
- FSM states: IDLE, REQ.
- IDLE: if store_req_in & ~flush_in on a rising edge:
  - aligned: register address/data/mask, go to REQ.
  - misaligned: stay IDLE, pulse misaligned_out for exactly the next cycle; no bus request, no outputs change.
- Misaligned rules: SH with addr[0]=1; SW (or 11) with addr[1:0]!=00. SB is never misaligned.
- Data/mask:
  - SB: data={4{rs2[7:0]}}, mask=4'b0001<<addr[1:0].
  - SH: data={2{rs2[15:0]}}, mask=addr[1]?4'b1100:4'b0011.
  - SW: data=rs2, mask=4'b1111.
- REQ: wr_req_out=1.
  - d_addr_out, data_out and wr_mask_out are stable until the handshake completes.
  - Transfer completes on a rising edge with wr_req_out & wr_ack_in; return to IDLE. wr_req_out drops the following cycle and data/addr/mask outputs hold their last values.
  - store_req_in and flush_in are ignored in REQ; a committed write is never cancelled by flush.
- Latency: store accepted at edge N → wr_req_out high from N. If ack is high at edge N+1, IDLE from N+1. Minimum occupancy is one REQ cycle; back-to-back stores are not accepted in the same cycle the previous one completes (capture only from IDLE).
- stall_out (combinational) = (state==REQ & ~wr_ack_in) | (state==IDLE & store_req_in & ~flush_in & aligned). The pipeline is held until the ack cycle.
- wr_ack_in while in IDLE is ignored.

Optional Feature:
MSRV32_STORE_TIMEOUT_EN
- Defined: an 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without ack. When the count reaches TIMEOUT_CYCLES with no ack, the transaction is aborted: wr_req_out deasserts, the FSM returns to IDLE, bus_err_out pulses for one cycle, and stall_out drops.
- Undefined: no counter; REQ waits indefinitely; bus_err_out tied to 0.

Test Plan:
- SW: addr 0x0000_1000, rs2 0xDEADBEEF, ack held high → one REQ cycle; d_addr 0x1000, data 0xDEADBEEF, mask 1111; stall high one cycle.
- SB: addr 0x0000_2003, rs2 0x0000_00A5, ack delayed 3 cycles → d_addr 0x2000, data 0xA5A5A5A5, mask 1000; req/addr/data stable 4 cycles; stall high until the ack edge.
- SH: addr 0x0000_3002, rs2 0x1234_5678 → data 0x56785678, mask 1100. SH at 0x3001 → misaligned_out one-cycle pulse; wr_req_out stays 0; stall low.
- flush_in=1 with store_req_in=1 in IDLE → no request, no stall; flush_in=1 during REQ → write still completes on ack.
- Reset low during REQ (ack never given) → wr_req_out and all outputs 0 immediately; after release, a new SW is accepted normally.
- With MSRV32_STORE_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never asserted → wr_req_out drops after 16 REQ cycles; bus_err_out pulses once; FSM back in IDLE.
